// File: rtl/code_display_pkg.sv
// Shared constants and types for the six-digit OTP code display.
// The digit count is fixed; widths of the code, index and segment buses derive from it.
package code_display_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned CODE_W     = NUM_DIGITS * DIGIT_W;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [SEG_W-1:0]      SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0]      SEG_DASH  = 7'b0111111;
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = 6'b111111;

    typedef logic [SEG_W-1:0]   seg_t;
    typedef logic [IDX_W-1:0]   idx_t;
    typedef logic [DIGIT_W-1:0] digit_t;

    typedef struct packed {
        logic [NUM_DIGITS-1:0] an;
        seg_t                  seg;
    } disp_t;

    localparam disp_t DISP_BLANK = '{an: AN_OFF, seg: SEG_BLANK};

    // Active-low one-hot enable for the digit at position idx (digit 0 is rightmost).
    function automatic logic [NUM_DIGITS-1:0] digit_enable(input idx_t idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/code_display_bcd_to_seg7.sv
// BCD to active-low seven-segment decoder, segment order gfedcba.
// Non-decimal nibbles render as a dash so corrupted codes are visible rather than misleading.
module bcd_to_seg7
    import code_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/code_display.sv
// Multiplexed six-digit display for a one-time passcode: captures the code on a ready
// rising edge and scans the digits continuously at REFRESH_DIV clocks per digit.
module code_display
    import code_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned NUM_DIGITS  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] code,
    input  logic                    ready,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    shown
);

    localparam int unsigned      PRE_W    = $clog2(REFRESH_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam idx_t             IDX_LAST = idx_t'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]        pre_q, pre_d;
    idx_t                    idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] hold_q, hold_d;
    logic                    ready_prev_q, ready_prev_d;
    logic                    shown_q, shown_d;
    disp_t                   disp_q, disp_d;

    logic   capture;
    logic   advance;
    digit_t nibble;
    seg_t   nibble_seg;

    // Scan and capture are independent: a capture never disturbs the prescaler or index.
    always_comb begin
        capture      = ready & ~ready_prev_q;
        advance      = (pre_q == PRE_LAST);
        ready_prev_d = ready;

        pre_d = advance ? '0 : pre_q + 1'b1;
        idx_d = idx_q;
        if (advance) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        hold_d  = capture ? code : hold_q;
        shown_d = shown_q | capture;
    end

    assign nibble = digit_t'(hold_q >> {idx_q, 2'b00});

    bcd_to_seg7 u_bcd_to_seg7 (
        .bcd (nibble),
        .seg (nibble_seg)
    );

    always_comb begin
        disp_d = DISP_BLANK;
        if (shown_q) begin
            disp_d.an  = digit_enable(idx_q);
            disp_d.seg = nibble_seg;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q        <= '0;
            idx_q        <= '0;
            hold_q       <= '0;
            ready_prev_q <= 1'b0;
            shown_q      <= 1'b0;
            disp_q       <= DISP_BLANK;
        end else begin
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            hold_q       <= hold_d;
            ready_prev_q <= ready_prev_d;
            shown_q      <= shown_d;
            disp_q       <= disp_d;
        end
    end

    assign an    = disp_q.an;
    assign seg   = disp_q.seg;
    assign dp    = 1'b1;
    assign shown = shown_q;

endmodule

// File: doc/code_display.md
CODE_DISPLAY -- requirements
Module: code_display

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, SHALL set the clock cycles each digit is driven before the scan advances (legal range 2..2^20).
REQ-002 Parameter NUM_DIGITS, default 6, SHALL be the fixed digit count; no other value is supported.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 code  input  24  SHALL carry the OTP as six BCD nibbles; code[3:0] is the least significant digit.
REQ-006 ready  input  1  SHALL qualify code; the code is valid while high, and a new code is signalled by a 0->1 transition.
REQ-007 an  output  6  SHALL be the active-low digit enables; an[i]=0 lights digit i, and digit 0 is the rightmost.
REQ-008 seg  output  7  SHALL be the active-low segments, ordered gfedcba (seg[0]=a, seg[6]=g).
REQ-009 dp  output  1  SHALL be the active-low decimal point and SHALL be constant 1 (off).
REQ-010 shown  output  1  SHALL be high from the first code capture until the next reset.

Function
REQ-011 Edge detect: a register holds the previous ready; capture SHALL occur in each cycle where ready=1 and previous ready=0.
REQ-012 Capture: code SHALL be latched into a 24-bit holding register and shown SHALL set in that cycle; a level-high ready with no 0->1 transition SHALL NOT recapture.
REQ-013 Prescaler: the counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; at terminal count the digit index SHALL advance.
REQ-014 Digit index: the index SHALL count 0..5, and 5 SHALL wrap to 0; the full refresh period is 6*REFRESH_DIV cycles.
REQ-015 an and seg SHALL be registered from the current index and holding register, so they lag an index or capture change by exactly 1 cycle.
REQ-016 While shown=0, an SHALL be 6'b111111 and seg SHALL be 7'b1111111 (blank).
REQ-017 While shown=1, an SHALL be one-hot-low at the position of the index, and seg SHALL be the decode of holding-register nibble [4*idx+3:4*idx].
REQ-018 Decode (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 Nibbles 0xA..0xF SHALL decode to a dash, 7'b0111111 (segment g only).
REQ-020 If a capture and an index advance occur in the same cycle, both SHALL take effect, and the next registered output SHALL use the new index and the new code.
REQ-021 The scan SHALL run continuously and SHALL be unaffected by captures; a capture SHALL NOT reset the prescaler or the index.

Reset
REQ-022 On rst=1, the prescaler, index, holding register, previous-ready register and shown SHALL clear to 0 on the same edge.
REQ-023 In the cycle after reset, the outputs SHALL be an=6'b111111, seg=7'b1111111, dp=1, shown=0.
REQ-024 Reset asserted mid-scan SHALL blank the display on the next edge; if ready is still high after reset, a capture SHALL wait for a fresh 0->1 transition.
REQ-025 rst SHALL take priority over capture and over scan advance.

Structure
REQ-026 A shared package SHALL hold NUM_DIGITS, SEG_BLANK (7'b1111111), SEG_DASH (7'b0111111) and AN_OFF (6'b111111).
REQ-027 Combinational sub-module bcd_to_seg7 (4-bit in, 7-bit active-low out) SHALL implement REQ-018 and REQ-019, and SHALL be instantiated once.
REQ-028 The prescaler width SHALL be derived from REFRESH_DIV via $clog2.

Verification (REFRESH_DIV=4)
REQ-029 Reset applied for 2 cycles -> an=111111, seg=1111111, dp=1, shown=0 held for 30 cycles with ready=0.
REQ-030 code=24'h123456 with a 1-cycle ready pulse -> shown=1; over 24 cycles an steps 111110, 111101, 111011, 110111, 101111, 011111 (4 cycles each) with seg 0000010, 0010010, 0011001, 0110000, 0100100, 1111001 (digits 6, 5, 4, 3, 2, 1).
REQ-031 code=24'hA0F909 captured -> digits 5 and 3 show 0111111 and digit 4 shows 1000000; remaining digits decode correctly.
REQ-032 ready held high while code changes 24'h111111 -> 24'h222222 -> display stays all 1s; ready dropped and re-raised -> display shows all 2s.
REQ-033 ready rising edge in the same cycle as the index wrap 5->0 -> the next output is an=111110 with the new code's digit 0.
REQ-034 rst pulsed mid-scan with ready held high -> blank on the next cycle, and no capture until ready goes 0 then 1.
